// File: rtl/memory_bus_bridge_if.sv
// memory_bus_bridge_if: valid/ready data-memory command bus with a separate response phase
interface memory_bus_bridge_if;
  logic        valid;
  logic        ready;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic        ren;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  modport master(output valid, addr, wdata, wen, ren, input ready, rvalid, rdata, err);
  modport slave(input valid, addr, wdata, wen, ren, output ready, rvalid, rdata, err);
endinterface

// File: rtl/memory_bus_bridge.sv
// memory_bus_bridge: runs one stage-1 memory access as a bus transaction, stalling the pipeline meanwhile
module memory_bus_bridge #(parameter int TIMEOUT_CYCLES = 255) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] ram_addr_i,
  input  logic [31:0] ram_wdata_i,
  input  logic [3:0]  ram_wen_i,
  input  logic        ram_ren_i,
  input  logic        ram_misaligned_i,
  output logic        stall_o,
  output logic [31:0] ram_data_o,
  output logic        fault_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [29:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wen_o,
  output logic        bus_ren_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);
  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
  state_t st, nxt;
  logic access, go, fault_q, tmo;
  assign access = ~rst_i & (ram_ren_i | (|ram_wen_i));
  assign go = access & ~ram_misaligned_i;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = (st == CMD || st == RESP) && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= (st == CMD || st == RESP) ? cnt + 16'd1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    stall_o = st == CMD || st == RESP;
    fault_o = st == DONE && fault_q;
    bus_valid_o = st == CMD;
    if (st == IDLE) begin
      nxt = go ? CMD : IDLE;
      stall_o = go;
      fault_o = access & ram_misaligned_i;
    end
    if (st == CMD) nxt = tmo ? DONE : bus_ready_i ? RESP : CMD;
    if (st == RESP) nxt = (bus_rvalid_i || tmo) ? DONE : RESP;
    if (st == DONE) nxt = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
      bus_wen_o <= '0;
      bus_ren_o <= 1'b0;
      ram_data_o <= '0;
      fault_q <= 1'b0;
    end else begin
      if (st == IDLE && go) begin
        bus_addr_o <= ram_addr_i;
        bus_wdata_o <= ram_wdata_i;
        bus_wen_o <= ram_wen_i;
        bus_ren_o <= ram_ren_i & ~(|ram_wen_i);
      end
      if (st == RESP && bus_rvalid_i) begin
        ram_data_o <= (bus_ren_o && !bus_err_i) ? bus_rdata_i : '0;
        fault_q <= bus_err_i;
      end else if (tmo) begin
        ram_data_o <= '0;
        fault_q <= 1'b1;
      end
      if (st == DONE) fault_q <= 1'b0;
    end
endmodule

// File: tb/tb_memory_bus_bridge.sv
// tb_memory_bus_bridge: table-driven per-cycle vectors plus hand sequences for reset and timeout
module tb_memory_bus_bridge;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [29:0] ram_addr_i = '0;
  logic [31:0] ram_wdata_i = '0;
  logic [3:0] ram_wen_i = '0;
  logic ram_ren_i = 1'b0, ram_misaligned_i = 1'b0;
  logic stall_o, fault_o;
  logic [31:0] ram_data_o;
  logic bus_valid_o, bus_ren_o;
  logic [29:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0] bus_wen_o;
  logic bus_ready_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  int errors = 0, checks = 0;
  memory_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ram_addr_i(ram_addr_i), .ram_wdata_i(ram_wdata_i),
    .ram_wen_i(ram_wen_i), .ram_ren_i(ram_ren_i), .ram_misaligned_i(ram_misaligned_i),
    .stall_o(stall_o), .ram_data_o(ram_data_o), .fault_o(fault_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wen_o(bus_wen_o), .bus_ren_o(bus_ren_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic ren; logic [3:0] wen; logic mis; logic [29:0] addr; logic [31:0] wdata;
    logic rdy; logic rv; logic [31:0] rdata; logic err;
    logic stall; logic fault; logic valid; logic [31:0] rd;
    logic [29:0] baddr; logic [3:0] bwen; logic bren; logic [31:0] bwdata;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(logic ren, logic [3:0] wen, logic mis, logic [29:0] addr, logic [31:0] wdata,
                             logic rdy, logic rv, logic [31:0] rdata, logic err,
                             logic stall, logic fault, logic valid, logic [31:0] rd,
                             logic [29:0] baddr, logic [3:0] bwen, logic bren, logic [31:0] bwdata);
    vec_t t;
    t.ren = ren; t.wen = wen; t.mis = mis; t.addr = addr; t.wdata = wdata;
    t.rdy = rdy; t.rv = rv; t.rdata = rdata; t.err = err;
    t.stall = stall; t.fault = fault; t.valid = valid; t.rd = rd;
    t.baddr = baddr; t.bwen = bwen; t.bren = bren; t.bwdata = bwdata;
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic ren, input logic [3:0] wen, input logic [29:0] addr,
                       input logic rdy, input logic rv, input logic [31:0] rdata);
    ram_ren_i = ren; ram_wen_i = wen; ram_addr_i = addr; ram_misaligned_i = 1'b0;
    bus_ready_i = rdy; bus_rvalid_i = rv; bus_rdata_i = rdata; bus_err_i = 1'b0;
  endtask
  initial begin
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,0,32'h0,0,        1,0,0,32'h0,       30'h0,  4'h0,0,32'h0));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,1,32'hBAD,0,      1,0,1,32'h0,       30'h123,4'h0,1,32'h55));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,0,32'h0,0,        1,0,1,32'h0,       30'h123,4'h0,1,32'h55));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      1,0,32'h0,0,        1,0,1,32'h0,       30'h123,4'h0,1,32'h55));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,0,32'h0,0,        1,0,0,32'h0,       30'h123,4'h0,1,32'h55));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,0,32'h0,0,        1,0,0,32'h0,       30'h123,4'h0,1,32'h55));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,1,32'h12345678,0, 1,0,0,32'h0,       30'h123,4'h0,1,32'h55));
    tv.push_back(v(1,4'h0,0,30'h123,32'h55,      0,0,32'h0,0,        0,0,0,32'h12345678,30'h123,4'h0,1,32'h55));
    tv.push_back(v(0,4'hF,0,30'h10,32'hDEADBEEF, 0,0,32'h0,0,        1,0,0,32'h12345678,30'h123,4'h0,1,32'h55));
    tv.push_back(v(0,4'hF,0,30'h10,32'hDEADBEEF, 1,0,32'h0,0,        1,0,1,32'h12345678,30'h10, 4'hF,0,32'hDEADBEEF));
    tv.push_back(v(0,4'hF,0,30'h10,32'hDEADBEEF, 0,1,32'hCAFEF00D,0, 1,0,0,32'h12345678,30'h10, 4'hF,0,32'hDEADBEEF));
    tv.push_back(v(0,4'hF,0,30'h10,32'hDEADBEEF, 0,0,32'h0,0,        0,0,0,32'h0,       30'h10, 4'hF,0,32'hDEADBEEF));
    tv.push_back(v(1,4'h3,0,30'h2A,32'h11112222, 0,0,32'h0,0,        1,0,0,32'h0,       30'h10, 4'hF,0,32'hDEADBEEF));
    tv.push_back(v(1,4'h3,0,30'h2A,32'h11112222, 1,0,32'h0,0,        1,0,1,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(1,4'h3,0,30'h2A,32'h11112222, 0,1,32'h77777777,0, 1,0,0,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(1,4'h3,0,30'h2A,32'h11112222, 0,0,32'h0,0,        0,0,0,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(1,4'h0,1,30'h3F,32'h0,        0,0,32'h0,0,        0,1,0,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(1,4'h0,1,30'h3F,32'h0,        0,0,32'h0,0,        0,1,0,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(0,4'h0,0,30'h0,32'h0,         0,0,32'h0,0,        0,0,0,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(1,4'h0,0,30'h4,32'h0,         0,0,32'h0,0,        1,0,0,32'h0,       30'h2A, 4'h3,0,32'h11112222));
    tv.push_back(v(1,4'h0,0,30'h4,32'h0,         1,1,32'h99,0,       1,0,1,32'h0,       30'h4,  4'h0,1,32'h0));
    tv.push_back(v(1,4'h0,0,30'h4,32'h0,         0,1,32'h5A5A5A5A,0, 1,0,0,32'h0,       30'h4,  4'h0,1,32'h0));
    tv.push_back(v(0,4'h0,0,30'h0,32'h0,         0,0,32'h0,0,        0,0,0,32'h5A5A5A5A,30'h4,  4'h0,1,32'h0));
    tv.push_back(v(1,4'h0,0,30'h8,32'h0,         0,0,32'h0,0,        1,0,0,32'h5A5A5A5A,30'h4,  4'h0,1,32'h0));
    tv.push_back(v(1,4'h0,0,30'h8,32'h0,         1,0,32'h0,0,        1,0,1,32'h5A5A5A5A,30'h8,  4'h0,1,32'h0));
    tv.push_back(v(1,4'h0,0,30'h8,32'h0,         0,1,32'hFFFFFFFF,1, 1,0,0,32'h5A5A5A5A,30'h8,  4'h0,1,32'h0));
    tv.push_back(v(1,4'h0,0,30'h8,32'h0,         0,0,32'h0,0,        0,1,0,32'h0,       30'h8,  4'h0,1,32'h0));
    tv.push_back(v(0,4'h0,0,30'h0,32'h0,         0,0,32'h0,0,        0,0,0,32'h0,       30'h8,  4'h0,1,32'h0));
    tv.push_back(v(0,4'h1,0,30'hC,32'hAB,        0,0,32'h0,0,        1,0,0,32'h0,       30'h8,  4'h0,1,32'h0));
    tv.push_back(v(0,4'h1,0,30'hC,32'hAB,        1,0,32'h0,0,        1,0,1,32'h0,       30'hC,  4'h1,0,32'hAB));
    tv.push_back(v(0,4'h1,0,30'hC,32'hAB,        0,1,32'h0,1,        1,0,0,32'h0,       30'hC,  4'h1,0,32'hAB));
    tv.push_back(v(0,4'h0,0,30'h0,32'h0,         0,0,32'h0,0,        0,1,0,32'h0,       30'hC,  4'h1,0,32'hAB));
    @(negedge clk_i); #1;
    chk("reset valid", {31'b0, bus_valid_o}, 32'h0);
    chk("reset stall", {31'b0, stall_o}, 32'h0);
    chk("reset fault", {31'b0, fault_o}, 32'h0);
    chk("reset ram_data", ram_data_o, 32'h0);
    chk("reset bus_addr", {2'b0, bus_addr_o}, 32'h0);
    chk("reset bus_wdata", bus_wdata_o, 32'h0);
    chk("reset bus_wen_ren", {27'b0, bus_wen_o, bus_ren_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk_i);
      ram_ren_i = tv[i].ren; ram_wen_i = tv[i].wen; ram_misaligned_i = tv[i].mis;
      ram_addr_i = tv[i].addr; ram_wdata_i = tv[i].wdata;
      bus_ready_i = tv[i].rdy; bus_rvalid_i = tv[i].rv; bus_rdata_i = tv[i].rdata; bus_err_i = tv[i].err;
      #1;
      chk($sformatf("v%0d stall", i), {31'b0, stall_o}, {31'b0, tv[i].stall});
      chk($sformatf("v%0d fault", i), {31'b0, fault_o}, {31'b0, tv[i].fault});
      chk($sformatf("v%0d valid", i), {31'b0, bus_valid_o}, {31'b0, tv[i].valid});
      chk($sformatf("v%0d ram_data", i), ram_data_o, tv[i].rd);
      chk($sformatf("v%0d bus_addr", i), {2'b0, bus_addr_o}, {2'b0, tv[i].baddr});
      chk($sformatf("v%0d bus_wen_ren", i), {27'b0, bus_wen_o, bus_ren_o}, {27'b0, tv[i].bwen, tv[i].bren});
      chk($sformatf("v%0d bus_wdata", i), bus_wdata_o, tv[i].bwdata);
    end
    @(negedge clk_i); drive(1, 4'h0, 30'h1, 0, 0, 32'h0);
    @(negedge clk_i); #1;
    chk("rstcmd valid before", {31'b0, bus_valid_o}, 32'h1);
    rst_i = 1'b1; #1;
    chk("rstcmd valid", {31'b0, bus_valid_o}, 32'h0);
    chk("rstcmd stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b0; #1;
    chk("rstcmd relaunch stall", {31'b0, stall_o}, 32'h1);
    @(negedge clk_i); bus_ready_i = 1'b1; #1;
    chk("rstresp cmd valid", {31'b0, bus_valid_o}, 32'h1);
    @(negedge clk_i); bus_ready_i = 1'b0; #1;
    chk("rstresp in resp stall", {31'b0, stall_o}, 32'h1);
    rst_i = 1'b1; #1;
    chk("rstresp stall", {31'b0, stall_o}, 32'h0);
    chk("rstresp valid", {31'b0, bus_valid_o}, 32'h0);
    chk("rstresp fault", {31'b0, fault_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b0; drive(0, 4'h0, 30'h0, 0, 1, 32'hDEAD0001);
    @(negedge clk_i); bus_rvalid_i = 1'b0; #1;
    chk("stray rvalid ram_data", ram_data_o, 32'h0);
    chk("stray rvalid stall", {31'b0, stall_o}, 32'h0);
    chk("stray rvalid fault", {31'b0, fault_o}, 32'h0);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    @(negedge clk_i); drive(1, 4'h0, 30'h5, 0, 0, 32'h0); #1;
    chk("tmo launch stall", {31'b0, stall_o}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i); #1;
      chk($sformatf("tmo cmd%0d valid", i), {31'b0, bus_valid_o}, 32'h1);
    end
    @(negedge clk_i); #1;
    chk("tmo done fault", {31'b0, fault_o}, 32'h1);
    chk("tmo done valid", {31'b0, bus_valid_o}, 32'h0);
    chk("tmo done stall", {31'b0, stall_o}, 32'h0);
    chk("tmo done ram_data", ram_data_o, 32'h0);
    @(negedge clk_i); drive(0, 4'h0, 30'h0, 0, 1, 32'h1234);
    @(negedge clk_i); bus_rvalid_i = 1'b0; #1;
    chk("tmo late rvalid ram_data", ram_data_o, 32'h0);
    chk("tmo late fault", {31'b0, fault_o}, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
